// File: rtl/conv_frame_writer_if.sv
// Frame memory write port: one word per memWe pulse, address and data alongside.
interface conv_frame_writer_if #(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned ADDR_WIDTH = 19
);
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [WORD_SIZE-1:0]  memData;

  modport master (output memWe, memAddr, memData);
  modport slave  (input  memWe, memAddr, memData);
endinterface

// File: rtl/conv_frame_writer.sv
// Captures the free-running convolution output stream, drops pipeline-fill and row
// wrap-around samples, and writes interior pixels in raster order to frame memory.
module conv_frame_writer #(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned ROW_SIZE   = 540,
  parameter int unsigned NUM_ROWS   = 540,
  parameter int unsigned SKIP       = 1086,
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WORD_SIZE-1:0]   pixelIn,
  conv_frame_writer_if.master    mem,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned ColW   = $clog2(ROW_SIZE);
  localparam int unsigned RowW   = $clog2(NUM_ROWS);
  localparam int unsigned FlushW = $clog2(SKIP + 1);

  localparam logic [ColW-1:0]   ColWrap   = ColW'(ROW_SIZE - 1);
  localparam logic [ColW-1:0]   ColKeep   = ColW'(ROW_SIZE - 2);
  localparam logic [ColW-1:0]   ColFinal  = ColW'(ROW_SIZE - 3);
  localparam logic [RowW-1:0]   RowFinal  = RowW'(NUM_ROWS - 3);
  localparam logic [FlushW-1:0] FlushLoad = FlushW'(SKIP - 1);

  typedef enum logic [1:0] {StIdle, StFlush, StCapture, StDone} state_e;

  state_e                state_q, state_d;
  logic [FlushW-1:0]     flush_q;
  logic [ColW-1:0]       col_q;
  logic [RowW-1:0]       row_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic accept;
  logic frame_end;

  // The last two samples of every row are line-buffer wrap-around and are dropped.
  assign accept    = (state_q == StCapture) && (col_q < ColKeep);
  assign frame_end = (state_q == StCapture) && (row_q == RowFinal) && (col_q == ColFinal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start) state_d = (SKIP == 1) ? StCapture : StFlush;
      StFlush:   if (flush_q <= FlushW'(1)) state_d = StCapture;
      StCapture: if (frame_end) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      wr_addr_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            flush_q   <= FlushLoad;
            col_q     <= '0;
            row_q     <= '0;
            wr_addr_q <= '0;
          end
        end
        StFlush: flush_q <= flush_q - 1'b1;
        StCapture: begin
          if (col_q == ColWrap) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
          // Running address replaces row*(ROW_SIZE-2)+col.
          if (accept) wr_addr_q <= wr_addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    we_d   = accept;
    addr_d = accept ? wr_addr_q : addr_q;
    data_d = accept ? pixelIn : data_q;
    busy_d = (state_d != StIdle);
    done_d = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign mem.memWe   = we_q;
  assign mem.memAddr = addr_q;
  assign mem.memData = data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
